// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store unit and its bus interface.
package mem_access_unit_pkg;

  localparam int unsigned BusAw  = 32;
  localparam int unsigned BusDw  = 32;
  localparam int unsigned BusBeW = BusDw / 8;

  typedef enum logic [1:0] {
    SzByte    = 2'b00,
    SzHalf    = 2'b01,
    SzWord    = 2'b10,
    SzIllegal = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  // Alignment rule for a given access size and byte offset.
  function automatic logic is_aligned(size_e sz, logic [1:0] off);
    logic ok;
    case (sz)
      SzHalf:  ok = ~off[0];
      SzWord:  ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide req/ack data bus with byte enables.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                req;
  logic                we;
  logic [BusAw-1:0]    addr;
  logic [BusBeW-1:0]   be;
  logic [BusDw-1:0]    wdata;
  logic [BusDw-1:0]    rdata;
  logic                ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load lane select plus sign/zero extension from a 32-bit bus word.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (size_i)
      SzByte:  data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SzHalf:  data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: turns core memory requests into req/ack bus accesses,
// stalling the core while an access is in flight.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          size,
  input  logic                ld_unsigned,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                stall,
  output logic                addr_err,
  output logic                bus_err,
  mem_access_unit_if.master   bus
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic        req_q, req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  size_e       size_in;
  logic        any_req;
  logic        legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_data;

  assign size_in = size_e'(size);
  assign any_req = mem_rd | mem_wr;
  assign legal   = (mem_rd ^ mem_wr) && (size_in != SzIllegal) && is_aligned(size_in, addr[1:0]);

  // Store lanes are replicated so the slave can pick any enabled byte lane.
  always_comb begin
    be_new    = 4'b0000;
    wdata_new = wdata;
    case (size_in)
      SzByte: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      SzHalf: begin
        be_new    = 4'b0011 << addr[1:0];
        wdata_new = {2{wdata[15:0]}};
      end
      SzWord: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
      default: begin
        be_new    = 4'b0000;
        wdata_new = wdata;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i    (bus.rdata),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    req_d      = req_q;
    bus_addr_d = bus_addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    stall      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (legal) begin
          stall      = 1'b1;
          off_d      = addr[1:0];
          size_d     = size_in;
          uns_d      = ld_unsigned;
          we_d       = mem_wr;
          cnt_d      = 8'd0;
          req_d      = 1'b1;
          bus_addr_d = {addr[31:2], 2'b00};
          be_d       = be_new;
          wdata_d    = wdata_new;
          state_d    = StBusy;
        end else if (any_req) begin
          addr_err_d = 1'b1;
        end
      end
      StBusy: begin
        stall = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.ack) begin
          if (!we_q) rdata_d = ld_data;
          req_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          if (!we_q) rdata_d = 32'd0;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      off_q      <= 2'b00;
      size_q     <= SzByte;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 8'd0;
      rdata_q    <= 32'd0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      req_q      <= 1'b0;
      bus_addr_q <= 32'd0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
      req_q      <= req_d;
      bus_addr_q <= bus_addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = bus_addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

endmodule
